// File: rtl/axi_read_arbiter_if.sv
// Bundle of every AR/R signal around the read arbiter: two requester ports, the AXI slave side, and status.
// The slave modport is the arbiter's own view. The master modport is the view of the environment that drives it.
interface axi_read_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Port 0: icache refill
   logic                  m0_arvalid;
   logic                  m0_arready;
   logic [ADDR_WIDTH-1:0] m0_araddr;
   logic [3:0]            m0_arlen;
   logic [2:0]            m0_arsize;
   logic [1:0]            m0_arburst;
   logic                  m0_rvalid;
   logic                  m0_rready;
   logic [DATA_WIDTH-1:0] m0_rdata;
   logic                  m0_rlast;
   logic [1:0]            m0_rresp;

   // Port 1: data side
   logic                  m1_arvalid;
   logic                  m1_arready;
   logic [ADDR_WIDTH-1:0] m1_araddr;
   logic [3:0]            m1_arlen;
   logic [2:0]            m1_arsize;
   logic [1:0]            m1_arburst;
   logic                  m1_rvalid;
   logic                  m1_rready;
   logic [DATA_WIDTH-1:0] m1_rdata;
   logic                  m1_rlast;
   logic [1:0]            m1_rresp;

   // Shared AXI slave side
   logic                  s_arvalid;
   logic                  s_arready;
   logic [ADDR_WIDTH-1:0] s_araddr;
   logic [3:0]            s_arlen;
   logic [2:0]            s_arsize;
   logic [1:0]            s_arburst;
   logic                  s_rvalid;
   logic                  s_rready;
   logic [DATA_WIDTH-1:0] s_rdata;
   logic                  s_rlast;
   logic [1:0]            s_rresp;

   logic                  busy;
   logic                  owner;

   modport slave (
      input  m0_arvalid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_rready,
      output m0_arready, m0_rvalid, m0_rdata, m0_rlast, m0_rresp,
      input  m1_arvalid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_rready,
      output m1_arready, m1_rvalid, m1_rdata, m1_rlast, m1_rresp,
      output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
      input  s_arready, s_rvalid, s_rdata, s_rlast, s_rresp,
      output busy, owner
   );

   modport master (
      output m0_arvalid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_rready,
      input  m0_arready, m0_rvalid, m0_rdata, m0_rlast, m0_rresp,
      output m1_arvalid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_rready,
      input  m1_arready, m1_rvalid, m1_rdata, m1_rlast, m1_rresp,
      input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
      output s_arready, s_rvalid, s_rdata, s_rlast, s_rresp,
      input  busy, owner
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between the icache (port 0) and the data side (port 1).
// It keeps one transaction in flight. Port 1 has priority, and a starvation guard guarantees port 0 makes progress.
module axi_read_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   axi_read_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_owner;
   logic [3:0]            r_starve_cnt;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [3:0]            r_arlen;
   logic [2:0]            r_arsize;
   logic [1:0]            r_arburst;

   logic w_starved;
   logic w_grant0;
   logic w_grant1;
   logic w_in_data;
   logic w_route0;
   logic w_route1;
   logic w_owner_rready;
   logic w_r_done;

   // R-channel routing. Only the owner sees the beats. The non-owner outputs are held at zero.
   assign w_in_data      = (r_state == DATA);
   assign w_route0       = w_in_data && !r_owner;
   assign w_route1       = w_in_data &&  r_owner;
   assign w_owner_rready = r_owner ? bus.m1_rready : bus.m0_rready;
   assign w_r_done       = bus.s_rvalid && bus.s_rready && bus.s_rlast;

   assign bus.s_rready   = w_in_data && w_owner_rready;

   assign bus.m0_rvalid  = w_route0 && bus.s_rvalid;
   assign bus.m0_rdata   = w_route0 ? bus.s_rdata : '0;
   assign bus.m0_rlast   = w_route0 && bus.s_rlast;
   assign bus.m0_rresp   = w_route0 ? bus.s_rresp : 2'b00;

   assign bus.m1_rvalid  = w_route1 && bus.s_rvalid;
   assign bus.m1_rdata   = w_route1 ? bus.s_rdata : '0;
   assign bus.m1_rlast   = w_route1 && bus.s_rlast;
   assign bus.m1_rresp   = w_route1 ? bus.s_rresp : 2'b00;

   // The AR side is driven straight from the registered request, so it stays stable for the whole stall.
   assign bus.s_arvalid  = (r_state == ADDR);
   assign bus.s_araddr   = r_araddr;
   assign bus.s_arlen    = r_arlen;
   assign bus.s_arsize   = r_arsize;
   assign bus.s_arburst  = r_arburst;

   assign bus.m0_arready = w_grant0;
   assign bus.m1_arready = w_grant1;
   assign bus.busy       = (r_state != IDLE);
   assign bus.owner      = r_owner;

   // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_grant0     = 1'b0;
      w_grant1     = 1'b0;
      w_starved    = bus.m0_arvalid && (r_starve_cnt == LP_LIMIT);
      case (r_state)
         IDLE: begin
            // No grant is issued in a reset cycle, so no requester sees a handshake that was discarded.
            if (!rst) begin
               if (bus.m1_arvalid && !w_starved) begin
                  w_grant1 = 1'b1;
               end else if (bus.m0_arvalid) begin
                  w_grant0 = 1'b1;
               end
            end
            if (w_grant0 || w_grant1) begin
               w_next_state = ADDR;
            end
         end
         ADDR: begin
            if (bus.s_arready) begin
               w_next_state = DATA;
            end
         end
         DATA: begin
            if (w_r_done) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here, so every register updates from the values it had before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_starve_cnt <= 4'd0;
         r_araddr     <= '0;
         r_arlen      <= 4'd0;
         r_arsize     <= 3'd0;
         r_arburst    <= 2'd0;
      end else begin
         r_state <= w_next_state;
         if (w_grant1) begin
            r_owner   <= 1'b1;
            r_araddr  <= bus.m1_araddr;
            r_arlen   <= bus.m1_arlen;
            r_arsize  <= bus.m1_arsize;
            r_arburst <= bus.m1_arburst;
            if (bus.m0_arvalid && (r_starve_cnt < LP_LIMIT)) begin
               r_starve_cnt <= r_starve_cnt + 4'd1;
            end
         end else if (w_grant0) begin
            r_owner      <= 1'b0;
            r_araddr     <= bus.m0_araddr;
            r_arlen      <= bus.m0_arlen;
            r_arsize     <= bus.m0_arsize;
            r_arburst    <= bus.m0_arburst;
            r_starve_cnt <= 4'd0;
         end
      end
   end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter. Every expected value below is computed by hand from the intended behaviour.
module tb_axi_read_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   axi_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_read_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input bit port, input logic [31:0] addr, input logic [3:0] len);
      if (port) begin
         bus.m1_arvalid = 1'b1; bus.m1_araddr = addr; bus.m1_arlen = len;
         bus.m1_arsize  = 3'd2; bus.m1_arburst = 2'd1;
      end else begin
         bus.m0_arvalid = 1'b1; bus.m0_araddr = addr; bus.m0_arlen = len;
         bus.m0_arsize  = 3'd2; bus.m0_arburst = 2'd1;
      end
   endtask

   // Check the grant in the current IDLE cycle, then one ADDR cycle accepted by the slave at once.
   task automatic grant_and_addr(input bit port, input logic [31:0] addr, input logic [3:0] len);
      #1;
      check("grant_m0_arready", bus.m0_arready, port == 1'b0);
      check("grant_m1_arready", bus.m1_arready, port == 1'b1);
      tick();
      if (port) bus.m1_arvalid = 1'b0; else bus.m0_arvalid = 1'b0;
      #1;
      check("addr_m0_arready", bus.m0_arready, 0);
      check("addr_m1_arready", bus.m1_arready, 0);
      check("addr_s_arvalid",  bus.s_arvalid, 1);
      check("addr_s_araddr",   bus.s_araddr, addr);
      check("addr_s_arlen",    bus.s_arlen, len);
      check("addr_s_arsize",   bus.s_arsize, 2);
      check("addr_s_arburst",  bus.s_arburst, 1);
      check("addr_owner",      bus.owner, port);
      check("addr_busy",       bus.busy, 1);
      bus.s_arready = 1'b1;
      tick();
      bus.s_arready = 1'b0;
   endtask

   task automatic data_phase(input bit port, input int n, input logic [31:0] base, input logic [1:0] resp);
      bus.m0_rready = (port == 1'b0);
      bus.m1_rready = (port == 1'b1);
      for (int i = 0; i < n; i++) begin
         bus.s_rvalid = 1'b1;
         bus.s_rdata  = base + 32'(i);
         bus.s_rlast  = (i == n - 1);
         bus.s_rresp  = resp;
         #1;
         check("beat_own_rvalid",   port ? bus.m1_rvalid : bus.m0_rvalid, 1);
         check("beat_other_rvalid", port ? bus.m0_rvalid : bus.m1_rvalid, 0);
         check("beat_own_rdata",    port ? bus.m1_rdata : bus.m0_rdata, base + 32'(i));
         check("beat_other_rdata",  port ? bus.m0_rdata : bus.m1_rdata, 0);
         check("beat_own_rlast",    port ? bus.m1_rlast : bus.m0_rlast, i == n - 1);
         check("beat_own_rresp",    port ? bus.m1_rresp : bus.m0_rresp, resp);
         check("beat_s_rready",     bus.s_rready, 1);
         tick();
      end
      bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; bus.s_rresp = 2'b00;
      bus.m0_rready = 1'b0; bus.m1_rready = 1'b0;
      #1;
      check("end_busy", bus.busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx;
      int cyc;

      rst = 1'b1;
      bus.m0_arvalid = 0; bus.m0_araddr = 0; bus.m0_arlen = 0; bus.m0_arsize = 0; bus.m0_arburst = 0;
      bus.m1_arvalid = 0; bus.m1_araddr = 0; bus.m1_arlen = 0; bus.m1_arsize = 0; bus.m1_arburst = 0;
      bus.m0_rready = 0; bus.m1_rready = 0;
      bus.s_arready = 0; bus.s_rvalid = 0; bus.s_rdata = 0; bus.s_rlast = 0; bus.s_rresp = 0;
      tick();
      tick();
      check("rst_busy",      bus.busy, 0);
      check("rst_owner",     bus.owner, 0);
      check("rst_s_arvalid", bus.s_arvalid, 0);
      check("rst_s_araddr",  bus.s_araddr, 0);
      check("rst_s_rready",  bus.s_rready, 0);
      check("rst_m0_arready", bus.m0_arready, 0);
      rst = 1'b0;
      tick();

      // A stray R beat while IDLE is ignored.
      bus.s_rvalid = 1'b1; bus.s_rdata = 32'hDEAD; bus.s_rlast = 1'b1;
      bus.m0_rready = 1'b1; bus.m1_rready = 1'b1;
      #1;
      check("spur_s_rready",  bus.s_rready, 0);
      check("spur_m0_rvalid", bus.m0_rvalid, 0);
      check("spur_m1_rvalid", bus.m1_rvalid, 0);
      check("spur_m0_rdata",  bus.m0_rdata, 0);
      tick();
      check("spur_busy", bus.busy, 0);
      bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; bus.m0_rready = 1'b0; bus.m1_rready = 1'b0;

      // Port 0 alone: an 8-beat refill.
      request(0, 32'h1FC00020, 4'd7);
      grant_and_addr(0, 32'h1FC00020, 4'd7);
      data_phase(0, 8, 32'h100, 2'b00);

      // Both ports request together: port 1 wins, and port 0 is granted right after port 1's RLAST.
      request(1, 32'h8000_0040, 4'd1);
      request(0, 32'h1FC00100, 4'd3);
      grant_and_addr(1, 32'h8000_0040, 4'd1);
      data_phase(1, 2, 32'h200, 2'b10);
      grant_and_addr(0, 32'h1FC00100, 4'd3);
      data_phase(0, 4, 32'h300, 2'b00);

      // Starvation: port 1 wins four times, port 0 takes the fifth grant, then port 1 wins again.
      request(0, 32'h3000, 4'd0);
      for (int k = 0; k < 4; k++) begin
         request(1, 32'h2000 + 32'(k * 16), 4'd0);
         grant_and_addr(1, 32'h2000 + 32'(k * 16), 4'd0);
         data_phase(1, 1, 32'h400 + 32'(k), 2'b00);
      end
      request(1, 32'h2040, 4'd0);
      grant_and_addr(0, 32'h3000, 4'd0);
      data_phase(0, 1, 32'h500, 2'b00);
      request(0, 32'h3010, 4'd0);
      grant_and_addr(1, 32'h2040, 4'd0);
      data_phase(1, 1, 32'h600, 2'b00);
      grant_and_addr(0, 32'h3010, 4'd0);
      data_phase(0, 1, 32'h700, 2'b00);

      // Backpressure: AR stalls for 3 cycles, then m0_rready toggles in the pattern 1,0,1 repeating.
      request(0, 32'h4000, 4'd7);
      #1;
      check("bp_m0_arready", bus.m0_arready, 1);
      tick();
      bus.m0_arvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_stall_arvalid", bus.s_arvalid, 1);
         check("bp_stall_araddr",  bus.s_araddr, 32'h4000);
         check("bp_stall_arlen",   bus.s_arlen, 7);
         tick();
      end
      bus.s_arready = 1'b1;
      #1;
      check("bp_accept_araddr", bus.s_araddr, 32'h4000);
      tick();
      bus.s_arready = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 40) begin
         bus.m0_rready = (cyc % 3 != 1);
         bus.s_rvalid  = 1'b1;
         bus.s_rdata   = 32'(idx);
         bus.s_rlast   = (idx == 7);
         #1;
         check("bp_s_rready",  bus.s_rready, bus.m0_rready);
         check("bp_m0_rvalid", bus.m0_rvalid, 1);
         check("bp_m0_rdata",  bus.m0_rdata, idx);
         tick();
         if (bus.m0_rready) idx++;
         cyc++;
      end
      check("bp_beats",  idx, 8);
      check("bp_cycles", cyc, 12);
      bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; bus.m0_rready = 1'b0;
      #1;
      check("bp_busy", bus.busy, 0);

      // Reset arrives during beat 3 of an 8-beat burst.
      request(0, 32'h5000, 4'd7);
      grant_and_addr(0, 32'h5000, 4'd7);
      bus.m0_rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.s_rvalid = 1'b1; bus.s_rdata = 32'(i); bus.s_rlast = 1'b0;
         tick();
      end
      bus.s_rdata = 32'd3;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy",      bus.busy, 0);
      check("mrst_m0_rvalid", bus.m0_rvalid, 0);
      check("mrst_m1_rvalid", bus.m1_rvalid, 0);
      check("mrst_s_rready",  bus.s_rready, 0);
      check("mrst_s_arvalid", bus.s_arvalid, 0);
      check("mrst_s_araddr",  bus.s_araddr, 0);
      check("mrst_m0_arready", bus.m0_arready, 0);
      check("mrst_m1_arready", bus.m1_arready, 0);
      bus.s_rvalid = 1'b0; bus.m0_rready = 1'b0;
      tick();
      request(0, 32'h6000, 4'd3);
      grant_and_addr(0, 32'h6000, 4'd3);
      data_phase(0, 4, 32'h60, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
